// File: rtl/ps2_kbd_mmio.sv
// rtl/ps2_kbd_mmio.sv - PS/2 keyboard receiver with scan-code FIFO on the CPU data bus
//
// Deserialises PS/2 frames into a byte FIFO that software pops through a
// memory-mapped DATA register and inspects/clears through STATUS.
//   DATA   @ BASE_ADDR   : {23'b0, valid, byte}; a load pops the head
//   STATUS @ BASE_ADDR+4 : {16'b0, count, 3'b0, ferr, perr, ovf, full, empty}
//                          store bit0 clears flags, bit1 flushes the FIFO
// Optional feature macro: PS2_KBD_PARITY_CHECK_EN (odd-parity check, perr flag).
//
// Ports:
//   clk, rst        CPU clock, asynchronous active-low reset
//   ps2_clk/data    raw PS/2 pins, asynchronous to clk
//   addr, wdata     CPU data address and store data
//   wren, rden      store / load strobes
//   rdata           combinational register read data (0 on address miss)
//   irq             high while the FIFO holds at least one byte
module ps2_kbd_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h10010000,
  parameter int          DEPTH     = 8,
  parameter int          TIMEOUT   = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wren,
  input  logic        rden,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int          AW          = $clog2(DEPTH);
  localparam int          TW          = $clog2(TIMEOUT + 1);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchronisers; reset to 1 so the bus looks idle and no edge is seen.
  logic r_clk_s1, r_clk_s2, r_clk_s3;
  logic r_dat_s1, r_dat_s2;
  logic w_fall;

  state_t r_state, w_state_nxt;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic          w_timeout;
  logic          w_par_ok;
  logic          w_push, w_ferr_set, w_perr_set;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_empty, w_full;
  logic          w_pop, w_wr, w_flush, w_clr, w_ovf_set;
  logic          r_ovf, r_ferr;
  logic          w_perr;
  logic [7:0]    w_count8;
  logic          w_unused_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_s3 & ~r_clk_s2;

  // Idle-time counter: restarts on every falling edge, parked while IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (r_state == S_IDLE || w_fall) begin
      r_to_cnt <= '0;
    end else if (!w_timeout) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_to_cnt == TW'(TIMEOUT));

`ifdef PS2_KBD_PARITY_CHECK_EN
  assign w_par_ok = ^{r_shift, r_parity};
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    w_perr_set  = 1'b0;
    if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!r_dat_s2) w_state_nxt = S_DATA;
        end
        S_DATA: begin
          if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        end
        S_PARITY: begin
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (r_dat_s2) begin
            if (w_par_ok) w_push = 1'b1;
            else          w_perr_set = 1'b1;
          end else begin
            w_ferr_set = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (r_state != S_IDLE && w_timeout) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Shift register, bit counter and parity latch follow the FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   r_bit_cnt <= '0;
        S_DATA: begin
          r_shift   <= {r_dat_s2, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        S_PARITY: r_parity <= r_dat_s2;
        default:  ;
      endcase
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop     = rden & (addr == BASE_ADDR) & ~w_empty;
  assign w_flush   = wren & (addr == STATUS_ADDR) & wdata[1];
  assign w_clr     = wren & (addr == STATUS_ADDR) & wdata[0];
  // A pop frees the slot, so a push into a full FIFO still lands that cycle.
  assign w_wr      = w_push & (~w_full | w_pop) & ~w_flush;
  assign w_ovf_set = w_push & w_full & ~w_pop & ~w_flush;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky flags: a new error on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovf  <= w_ovf_set  | (r_ovf  & ~w_clr);
      r_ferr <= w_ferr_set | (r_ferr & ~w_clr);
    end
  end

`ifdef PS2_KBD_PARITY_CHECK_EN
  logic r_perr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_perr <= 1'b0;
    else      r_perr <= w_perr_set | (r_perr & ~w_clr);
  end
  assign w_perr      = r_perr;
  assign w_unused_ok = &{1'b0, wdata[31:2]};
`else
  assign w_perr      = 1'b0;
  assign w_unused_ok = &{1'b0, wdata[31:2], w_perr_set, r_parity};
`endif

  assign w_count8 = 8'(r_count);

  always_comb begin
    rdata = 32'h0;
    if (addr == BASE_ADDR) begin
      if (!w_empty) rdata = {23'b0, 1'b1, r_mem[r_rptr]};
    end else if (addr == STATUS_ADDR) begin
      rdata = {16'b0, w_count8, 3'b0, r_ferr, w_perr, r_ovf, w_full, w_empty};
    end
  end

  assign irq = ~w_empty;

endmodule

// File: tb/tb_ps2_kbd_mmio.sv
// tb/tb_ps2_kbd_mmio.sv - directed table-driven bench for ps2_kbd_mmio
module tb_ps2_kbd_mmio;

  localparam logic [31:0] BASE = 32'h10010000;
  localparam logic [31:0] STAT = 32'h10010004;
  localparam int          TO   = 200;
  localparam int          H    = 8;

  localparam logic [1:0] OP_PEEK  = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  vec_t tab_rst  [4];
  vec_t tab_fill [12];

  ps2_kbd_mmio #(
    .BASE_ADDR(BASE),
    .DEPTH    (8),
    .TIMEOUT  (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .addr    (addr),
    .wdata   (wdata),
    .wren    (wren),
    .rden    (rden),
    .rdata   (rdata),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_peek(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    #1 d = rdata;
    @(posedge clk);
    #1 addr = 32'h0;
  endtask

  task automatic bus_load(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    rden = 1'b1;
    #1 d = rdata;
    @(posedge clk);
    #1 rden = 1'b0;
    addr = 32'h0;
  endtask

  task automatic bus_store(input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    addr  = a;
    wdata = w;
    wren  = 1'b1;
    @(posedge clk);
    #1 wren = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] d;
    case (v.op)
      OP_PEEK:  begin bus_peek(v.addr, d); chk(v.name, d, v.exp); end
      OP_LOAD:  begin bus_load(v.addr, d); chk(v.name, d, v.exp); end
      default:  bus_store(v.addr, v.wdata);
    endcase
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] w, input logic [31:0] e, input string n);
    vec_t v;
    v.op = op; v.addr = a; v.wdata = w; v.exp = e; v.name = n;
    return v;
  endfunction

  initial begin
    logic [31:0] d;

    tab_rst[0] = mk(OP_PEEK, STAT, 0, 32'h1, "rst_status");
    tab_rst[1] = mk(OP_PEEK, BASE, 0, 32'h0, "rst_data");
    tab_rst[2] = mk(OP_PEEK, BASE + 32'd8, 0, 32'h0, "miss_addr");
    tab_rst[3] = mk(OP_LOAD, BASE, 0, 32'h0, "rst_pop_empty");

    tab_fill[0] = mk(OP_PEEK, STAT, 0, 32'h806, "fill_status");
    for (int i = 0; i < 8; i++)
      tab_fill[1+i] = mk(OP_LOAD, BASE, 0, 32'h101 + i, $sformatf("pop_%0d", i));
    tab_fill[9]  = mk(OP_PEEK, STAT, 0, 32'h5, "drained_status");
    tab_fill[10] = mk(OP_STORE, STAT, 32'h1, 0, "clear_flags");
    tab_fill[11] = mk(OP_PEEK, STAT, 0, 32'h1, "cleared_status");

    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(tab_rst[i]);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    send_frame(8'h1C, 1'b0, 1'b1);
    chk("one_irq", {31'b0, irq}, 32'h1);
    bus_peek(STAT, d); chk("one_status", d, 32'h100);
    bus_load(BASE, d); chk("one_data", d, 32'h11C);
    bus_peek(BASE, d); chk("one_after", d, 32'h0);
    chk("one_irq_clr", {31'b0, irq}, 32'h0);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) run_vec(tab_fill[i]);

    send_frame(8'h1C, 1'b1, 1'b1);
    bus_peek(STAT, d);
`ifdef PS2_KBD_PARITY_CHECK_EN
    chk("badpar_status", d, 32'h9);
`else
    chk("badpar_status", d, 32'h100);
    bus_load(BASE, d); chk("badpar_data", d, 32'h11C);
`endif
    bus_store(STAT, 32'h1);

    send_frame(8'h33, 1'b0, 1'b0);
    bus_peek(STAT, d); chk("ferr_status", d, 32'h11);
    bus_store(STAT, 32'h1);
    bus_peek(STAT, d); chk("ferr_cleared", d, 32'h1);

    for (int i = 0; i < 3; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b1);
    bus_store(BASE, 32'hFF);
    bus_peek(STAT, d); chk("three_status", d, 32'h300);
    bus_peek(BASE, d); chk("three_head", d, 32'h140);
    bus_store(STAT, 32'h2);
    bus_peek(STAT, d); chk("flush_status", d, 32'h1);
    chk("flush_irq", {31'b0, irq}, 32'h0);

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TO + 20) @(negedge clk);
    bus_peek(STAT, d); chk("timeout_status", d, 32'h1);
    send_frame(8'h5A, 1'b0, 1'b1);
    bus_load(BASE, d); chk("after_timeout", d, 32'h15A);

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1);
    bus_peek(STAT, d); chk("rst_mid_status", d, 32'h100);
    bus_load(BASE, d); chk("rst_mid_data", d, 32'h1A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_mmio.md
# ps2_kbd_mmio

PS/2 keyboard receiver with a scan-code FIFO, exposed to the CPU as a memory-mapped peripheral. It sits directly downstream of the CPU's data-memory port and consumes the same ALU-computed address, store data and write-enable that drive data memory. The CPU-side address decoder selects this block's `rdata` in place of `data_memory.q` when the address hits `BASE_ADDR`. The block deserialises PS/2 frames, queues bytes, and lets software pop them and read or clear status.

## Interface
- `BASE_ADDR`, 32'h10010000: byte address of the DATA register. STATUS is at `BASE_ADDR+4`.
- `DEPTH`, 8: FIFO entries. Must be a power of two, from 2 to 16.
- `TIMEOUT`, 50000: idle `clk` cycles mid-frame before the receiver aborts the frame.
- `clk` in 1: CPU clock.
- `rst` in 1: asynchronous reset, active-low.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous to `clk`.
- `addr` in 32: CPU data address (ALU result).
- `wdata` in 32: store data (rt).
- `wren` in 1: store strobe.
- `rden` in 1: load strobe. The CPU asserts it for load instructions.
- `rdata` out 32: register read data. Combinational from `addr`; 0 when `addr` misses the block.
- `irq` out 1: high whenever the FIFO is non-empty.

## Operation
- Input sync: `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser. A third flop on the clock path forms the edge detector. A falling edge is a synced-previous value of 1 followed by a synced value of 0.
- Receiver FSM, advancing only on a falling edge:
  - IDLE: if data is 0, go to DATA with bit counter 0. If data is 1, stay in IDLE (glitch).
  - DATA: shift data in LSB-first. After bit 7, go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: if the stop bit is 1 and parity is OK, push the byte. If the stop bit is 0, set `ferr` and drop the byte. Return to IDLE in either case.
- Timeout: in any state other than IDLE, a counter runs and clears on every falling edge. When it reaches `TIMEOUT`, the FSM returns to IDLE. No flag is set and no byte is pushed.
- FIFO: read and write pointers of log2(DEPTH) bits wrap naturally. The count is log2(DEPTH)+1 bits.
  - A push when full drops the byte and sets sticky `ovf`.
  - A pop happens on a clock edge where `rden` is high, `addr==BASE_ADDR` and the FIFO is non-empty.
  - A pop when empty does nothing.
- DATA read value: {23'b0, valid, byte}.
  - valid=1 and byte = FIFO head when non-empty.
  - Value is 0x00000000 when empty.
- STATUS read value: {16'b0, count[7:0], 3'b0, ferr, perr, ovf, full, empty}.
- STATUS write (`wren` and `addr==BASE_ADDR+4`):
  - `wdata[0]`=1 clears `ovf`, `perr` and `ferr`.
  - `wdata[1]`=1 flushes the FIFO: pointers and count go to 0.
- Writes to DATA are ignored.
- Simultaneous events:
  - Push and pop on the same edge when non-empty: both happen and count is unchanged. When empty, only the push happens.
  - Flush and push on the same edge: flush wins and the byte is lost, with no `ovf`.
  - Error clear and a new error on the same edge: the new error wins (flag set).
  - Flush and pop on the same edge: flush wins.
- Reset values: FSM IDLE, pointers 0, count 0, all flags 0, `irq` 0, synchroniser flops 1 (bus idle). `rdata` is therefore 0 for DATA and 0x00000001 for STATUS.
- Reset mid-frame abandons the partial byte. The first frame after reset must start with a fresh start bit.

## Timing
- Falling-edge detection is 3 `clk` cycles after the `ps2_clk` pin falls.
- A byte is pushed on the `clk` edge that samples the stop bit. It is visible on `rdata` and `irq` from the next cycle.
- `rdata` has zero latency: it is combinational from `addr` and the registered state, valid in the same cycle as a single-cycle load.
- The pop and STATUS write take effect on the `clk` rising edge at the end of the load or store instruction's cycle.
- The data reported before a pop is the pre-pop head.
- Assumes `clk` ≥ 8× the PS/2 bit rate, so ≥ 160 kHz for a 20 kHz PS/2 clock.

## Configuration
- `PS2_KBD_PARITY_CHECK_EN` defined:
  - Odd parity is checked over the 8 data bits plus the parity bit.
  - On mismatch the byte is dropped and sticky `perr` is set.
- `PS2_KBD_PARITY_CHECK_EN` undefined:
  - The parity bit is sampled but ignored.
  - Every frame with a valid stop bit is pushed.
  - `perr` is tied to 0 and reads 0.

## Test plan
- Reset, then read STATUS -> 0x00000001. Read DATA -> 0x00000000. `irq`=0.
- Send frame 0x1C with correct odd parity (parity 0) and stop 1 -> `irq`=1. STATUS = 0x00000100. DATA load returns 0x0000011C. The next DATA read returns 0 and `irq`=0.
- Send 9 bytes 0x01..0x09 with DEPTH=8 and no pops -> STATUS = 0x00000806 (full, ovf). Eight pops return 0x101..0x108 in order.
- Send 0x1C with wrong parity -> with the macro: no push, STATUS = 0x00000009. Without the macro: byte pushed, STATUS = 0x00000100.
- Send a frame with stop bit 0 -> ferr set, no push. Store 0x1 to STATUS -> STATUS = 0x00000001. Store 0x2 with 3 bytes queued -> count 0.
- Drive a start bit plus 3 data bits, then idle for `TIMEOUT`+1 cycles -> FSM back in IDLE with no flag set. A following complete frame 0x5A is received as 0x0000015A.
